// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
package seg_pkg;

    localparam int NUM_W = 16;
    localparam int DIGITS = 4;
    localparam logic [NUM_W-1:0] DEFAULT_NUM = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin first-set search: returns the first asserted request at or
// after the start index, wrapping modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] pick,
    output logic             found
);

    int idx;

    // Scan offsets from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a
        // path with no assignment would infer a latch.
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N_REQ;
            if (req[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Grants the shared 4-digit display to one requester at a time in
// round-robin order, holding each owner for a minimum number of cycles.
module seg_display_arbiter
    import seg_pkg::NUM_W, seg_pkg::state_t, seg_pkg::IDLE, seg_pkg::ARB, seg_pkg::HOLD;
#(
    parameter int               N_REQ       = 3,
    parameter int               HOLD_CYCLES = 50_000_000,
    parameter logic [NUM_W-1:0] DEFAULT_NUM = seg_pkg::DEFAULT_NUM
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [NUM_W*N_REQ-1:0] req_num,
    output logic [N_REQ-1:0]       grant,
    output logic [NUM_W-1:0]       num,
    output logic                   blank,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [N_REQ-1:0] owner_mask;
    logic             owner_req;
    logic             others_req;
    logic             expired;
    logic [NUM_W-1:0] owner_num;
    logic [NUM_W-1:0] pick_num;

    // Search start, owner status and the selected value slices.
    always_comb begin
        start      = (last_owner == LAST_IDX) ? '0 : last_owner + IDX_W'(1);
        owner_mask = N_REQ'(1) << owner;
        owner_req  = |(req & owner_mask);
        others_req = |(req & ~owner_mask);
        expired    = (cnt == HOLD_LAST);
        owner_num  = req_num[NUM_W*int'(owner) +: NUM_W];
        pick_num   = req_num[NUM_W*int'(pick) +: NUM_W];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .start (start),
        .pick  (pick),
        .found (found)
    );

    // Arbitration FSM with hold counter and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            num        <= DEFAULT_NUM;
            blank      <= 1'b1;
            busy       <= 1'b0;
            cnt        <= '0;
            owner      <= '0;
            last_owner <= LAST_IDX;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    num <= DEFAULT_NUM;
                    if (|req) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (found) begin
                        state      <= HOLD;
                        grant      <= N_REQ'(1) << pick;
                        owner      <= pick;
                        last_owner <= pick;
                        num        <= pick_num;
                        cnt        <= '0;
                        blank      <= 1'b0;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        num   <= DEFAULT_NUM;
                        blank <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!owner_req || (expired && others_req)) begin
                        state <= ARB;
                        grant <= '0;
                    end else begin
                        num <= owner_num;
                        if (!expired) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    num   <= DEFAULT_NUM;
                    blank <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
